// File: rtl/lazy_seq_output_buffer.sv
// Sequence output FIFO between the lazy summary pipeline and the sequence serializer.
// Optional statistics counters are enabled by defining LAZY_SEQ_OUTPUT_STATS_EN.
module lazy_seq_output_buffer #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned AFULL_SLACK     = 5,
  parameter int unsigned SEQ_LL_BITS     = 16,
  parameter int unsigned SEQ_ML_BITS     = 16,
  parameter int unsigned SEQ_OFFSET_BITS = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_summary_done,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_delim,
  input  logic                       i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  output logic                       o_stall,
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_delim,
  output logic                       o_seq_eoj,
  output logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len,
  output logic                       o_job_done,
  output logic                       o_overflow
`ifdef LAZY_SEQ_OUTPUT_STATS_EN
  ,
  output logic [31:0]                o_stat_seq_cnt,
  output logic [31:0]                o_stat_lit_bytes,
  output logic [31:0]                o_stat_match_bytes,
  output logic [31:0]                o_stat_job_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] SlackC = CntW'(AFULL_SLACK);

  typedef enum logic [0:0] {StInJob, StEojSeen} job_state_e;

  // Entry storage, one array per field
  logic [SEQ_LL_BITS-1:0]     ll_mem_q      [FIFO_DEPTH];
  logic [SEQ_ML_BITS-1:0]     ml_mem_q      [FIFO_DEPTH];
  logic [SEQ_OFFSET_BITS-1:0] offset_mem_q  [FIFO_DEPTH];
  logic                       delim_mem_q   [FIFO_DEPTH];
  logic                       eoj_mem_q     [FIFO_DEPTH];
  logic [SEQ_ML_BITS-1:0]     overlap_mem_q [FIFO_DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [CntW-1:0] free_cnt;
  logic            overflow_q, overflow_d;
  logic            job_done_q, job_done_d;
  job_state_e      job_state_q, job_state_d;

  logic noop_summary;
  logic push_req;
  logic push_ok;
  logic push_drop;
  logic pop;
  logic full;
  logic head_eoj;

  assign noop_summary = (i_summary_ll == '0) && (i_summary_ml == '0) && !i_summary_eoj;
  assign push_req     = i_summary_done && !noop_summary;
  assign full         = (occ_q == DepthC);
  assign o_seq_valid  = (occ_q != '0);
  assign pop          = o_seq_valid && i_seq_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok      = push_req && (!full || pop);
  assign push_drop    = push_req && full && !pop;
  assign head_eoj     = eoj_mem_q[rd_ptr_q];

  assign free_cnt = DepthC - occ_q;
  assign o_stall  = (free_cnt <= SlackC);

  assign o_seq_ll          = ll_mem_q[rd_ptr_q];
  assign o_seq_ml          = ml_mem_q[rd_ptr_q];
  assign o_seq_offset      = offset_mem_q[rd_ptr_q];
  assign o_seq_delim       = delim_mem_q[rd_ptr_q];
  assign o_seq_eoj         = head_eoj;
  assign o_seq_overlap_len = overlap_mem_q[rd_ptr_q];
  assign o_job_done        = job_done_q;
  assign o_overflow        = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q || push_drop;
    job_done_d = pop && head_eoj;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Job boundary tracker; informational only, never gates data
  always_comb begin
    job_state_d = job_state_q;
    unique case (job_state_q)
      StInJob: begin
        if (push_ok && i_summary_eoj) begin
          job_state_d = StEojSeen;
        end
      end
      StEojSeen: begin
        if (push_ok) begin
          job_state_d = i_summary_eoj ? StEojSeen : StInJob;
        end
      end
      default: job_state_d = StInJob;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      job_done_q  <= 1'b0;
      job_state_q <= StInJob;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      job_done_q  <= job_done_d;
      job_state_q <= job_state_d;
    end
  end

  // Storage is reset so head fields read as zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ll_mem_q[i]      <= '0;
        ml_mem_q[i]      <= '0;
        offset_mem_q[i]  <= '0;
        delim_mem_q[i]   <= 1'b0;
        eoj_mem_q[i]     <= 1'b0;
        overlap_mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      ll_mem_q[wr_ptr_q]      <= i_summary_ll;
      ml_mem_q[wr_ptr_q]      <= i_summary_ml;
      offset_mem_q[wr_ptr_q]  <= i_summary_offset;
      delim_mem_q[wr_ptr_q]   <= i_summary_delim;
      eoj_mem_q[wr_ptr_q]     <= i_summary_eoj;
      overlap_mem_q[wr_ptr_q] <= i_summary_overlap_len;
    end
  end

`ifdef LAZY_SEQ_OUTPUT_STATS_EN
  logic [31:0] stat_seq_cnt_q, stat_lit_bytes_q, stat_match_bytes_q, stat_job_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_seq_cnt_q     <= '0;
      stat_lit_bytes_q   <= '0;
      stat_match_bytes_q <= '0;
      stat_job_cnt_q     <= '0;
    end else if (pop) begin
      stat_seq_cnt_q     <= stat_seq_cnt_q + 32'd1;
      stat_lit_bytes_q   <= stat_lit_bytes_q + 32'(ll_mem_q[rd_ptr_q]);
      stat_match_bytes_q <= stat_match_bytes_q + 32'(ml_mem_q[rd_ptr_q]);
      stat_job_cnt_q     <= stat_job_cnt_q + {31'd0, head_eoj};
    end
  end

  assign o_stat_seq_cnt     = stat_seq_cnt_q;
  assign o_stat_lit_bytes   = stat_lit_bytes_q;
  assign o_stat_match_bytes = stat_match_bytes_q;
  assign o_stat_job_cnt     = stat_job_cnt_q;
`endif

endmodule
